// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and MixColumns constants
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mix_state_t;

    localparam int STEP_W = 4;

    localparam logic [7:0] FWD_COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [7:0] INV_COEF [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] coef_for(input logic inv, input logic [1:0] idx);
        return inv ? INV_COEF[idx] : FWD_COEF[idx];
    endfunction

endpackage

// File: rtl/MultiplierGF.sv
// rtl/MultiplierGF.sv - combinational GF(2^8) byte times factor, AES polynomial 0x11b
module MultiplierGF (
    input  logic [7:0] inputNum,
    input  logic [7:0] factor,
    output logic [7:0] result
);

    logic [7:0] partial;

    // Shift-and-add: partial walks through inputNum * x^b, reduced each step.
    always_comb begin
        result  = 8'h00;
        partial = inputNum;
        for (int b = 0; b < 8; b++) begin
            if (factor[b]) begin
                result = result ^ partial;
            end
            partial = {partial[6:0], 1'b0} ^ (partial[7] ? 8'h1b : 8'h00);
        end
    end

endmodule

// File: rtl/mix_column_sequencer.sv
// rtl/mix_column_sequencer.sv - serial (Inv)MixColumns over one column, one product per cycle
module mix_column_sequencer
    import aes_pkg::*;
#(
    parameter logic BYPASS_ONE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_column,
    input  logic        inverse,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_column,
    output logic        busy
);

    mix_state_t        state;
    mix_state_t        state_next;
    logic [STEP_W-1:0] step;
    logic [7:0]        acc;
    logic [7:0]        acc_next;
    logic [31:0]       col_q;
    logic              mode_q;
    logic [23:0]       res_hi;
    logic [31:0]       out_q;

    logic [1:0]        k;
    logic [1:0]        i;
    logic [1:0]        cidx;
    logic [7:0]        s_k;
    logic [7:0]        coef;
    logic [7:0]        mult_result;
    logic [7:0]        product;
    logic              accept;

    assign k      = step[1:0];
    assign i      = step[3:2];
    assign cidx   = k - i;
    assign accept = (state == ST_IDLE) && in_valid;

    always_comb begin
        s_k = 8'h00;
        case (k)
            2'd0:    s_k = col_q[31:24];
            2'd1:    s_k = col_q[23:16];
            2'd2:    s_k = col_q[15:8];
            default: s_k = col_q[7:0];
        endcase
    end

    assign coef = coef_for(mode_q, cidx);

    MultiplierGF u_mult (
        .inputNum (s_k),
        .factor   (coef),
        .result   (mult_result)
    );

    assign product  = ((BYPASS_ONE != 1'b0) && (coef == 8'h01)) ? s_k : mult_result;
    assign acc_next = acc ^ product;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (in_valid) state_next = ST_COMPUTE;
            ST_COMPUTE: if (step == 4'd15) state_next = ST_DONE;
            ST_DONE:    if (out_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // r0..r2 collect in res_hi; r3 completes the column and publishes it at once,
    // so out_column never shows a half-built result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= '0;
            acc    <= 8'h00;
            col_q  <= 32'h0;
            mode_q <= 1'b0;
            res_hi <= 24'h0;
            out_q  <= 32'h0;
        end else if (accept) begin
            step   <= '0;
            acc    <= 8'h00;
            col_q  <= in_column;
            mode_q <= inverse;
        end else if (state == ST_COMPUTE) begin
            step <= step + 4'd1;
            if (k == 2'd3) begin
                acc <= 8'h00;
                case (i)
                    2'd0:    res_hi[23:16] <= acc_next;
                    2'd1:    res_hi[15:8]  <= acc_next;
                    2'd2:    res_hi[7:0]   <= acc_next;
                    default: out_q         <= {res_hi, acc_next};
                endcase
            end else begin
                acc <= acc_next;
            end
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign out_column = out_q;

endmodule

// File: doc/mix_column_sequencer.md
MIX_COLUMN_SEQUENCER -- requirements
Module: mix_column_sequencer

Interface
REQ-001 The block SHALL have parameter BYPASS_ONE, default 1; when 1, coefficient 01 SHALL select the input byte directly, and when 0 it SHALL be sent through the multiplier.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, which SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a column is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a column.
REQ-006 The block SHALL have port in_column, input, 32 bits: bytes s0..s3, with s0 = [31:24] and s3 = [7:0].
REQ-007 The block SHALL have port inverse, input, 1 bit: 0 selects MixColumns and 1 selects InvMixColumns; it SHALL be sampled only at accept.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result column is held.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port out_column, output, 32 bits: result bytes r0..r3, in the same byte order as in_column.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL time-share exactly one GF(2^8) multiplier, a combinational byte-times-factor unit, for all products.
REQ-013 Each output byte SHALL be r[i] = XOR over k of C[(k-i) mod 4] * s[k].
REQ-014 The forward coefficients SHALL be C = {02,03,01,01}; the inverse coefficients SHALL be C = {0e,0b,0d,09}.
REQ-015 The FSM states SHALL be IDLE, COMPUTE and DONE.
REQ-016 IDLE transitions: in_ready = 1; when in_valid & in_ready at an edge, the block SHALL latch in_column and inverse, clear the accumulator and step counter, and go to COMPUTE.
REQ-017 COMPUTE SHALL last exactly 16 cycles, using a 4-bit step counter t = 4*i + k.
REQ-018 At each COMPUTE edge: acc <= acc ^ product(s[k], C[(k-i) mod 4]).
REQ-019 When k = 3, the new acc value SHALL be written to byte r[i] and acc SHALL clear.
REQ-020 After step t = 15, the block SHALL go to DONE.
REQ-021 Latency: out_valid SHALL rise after the 16th edge following the accept edge.
REQ-022 The per-column cycle count SHALL be independent of data, mode and BYPASS_ONE.
REQ-023 DONE: out_valid = 1, and out_column SHALL be stable until out_valid & out_ready at an edge, which returns the FSM to IDLE.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 in_ready SHALL be 0 in COMPUTE and DONE; in_valid SHALL be ignored in those states, with no queuing.
REQ-026 Throughput SHALL be at most one column per 18 cycles.
REQ-027 A change of inverse mid-operation SHALL have no effect, because the mode is latched.
REQ-028 out_column SHALL show the previous result or zero while not in DONE; consumers SHALL qualify it with out_valid.
REQ-029 All arithmetic SHALL be 8-bit XOR; no carries SHALL occur anywhere.

Reset
REQ-030 When rst_n is low, the FSM SHALL be IDLE, with out_valid = 0, busy = 0 and in_ready = 1.
REQ-031 When rst_n is low, out_column, acc, the step counter and the latched column/mode SHALL all be zero.
REQ-032 Reset asserted mid-COMPUTE or in DONE SHALL discard the column.
REQ-033 After rst_n deasserts, the first accept SHALL be possible at the first rising edge.

Structure
REQ-034 The shared aes package SHALL hold the FSM state enum, forward/inverse coefficient constants (arrays of 4 bytes) and the step-counter width.
REQ-035 The block SHALL instantiate the existing GF multiplier (MultiplierGF: inputNum, factor, result) exactly once; no other sub-module SHALL be used.
REQ-036 Coefficient selection and the bypass mux SHALL be combinational from the step counter and the latched mode.

Verification
REQ-037 Bench scenario, forward: in_column 32'hdb135345, inverse = 0 -> out_column 32'h8e4da1bc, with out_valid rising 16 edges after accept.
REQ-038 Bench scenario, inverse: 32'h8e4da1bc, inverse = 1 -> 32'hdb135345; then 32'h9fdc589d, inverse = 1 -> 32'hf20a225c.
REQ-039 Bench scenario, fixed points: 32'hc6c6c6c6 and 32'h01010101 SHALL map to themselves in both modes and for both BYPASS_ONE settings.
REQ-040 Bench scenario, backpressure: out_ready held low 10 cycles in DONE -> out_column stable and in_ready = 0 throughout; a second in_valid during that time is not accepted; it is accepted on the cycle after out_ready is high for one edge.
REQ-041 Bench scenario, reset mid-operation: rst_n pulsed low at COMPUTE step 7 -> out_valid = 0, out_column = 0 and in_ready = 1 immediately (asynchronously); the next column 32'hf20a225c forward -> 32'h9fdc589d.
REQ-042 Bench scenario, mode latch: inverse toggled every cycle during COMPUTE after accepting 32'hdb135345 with inverse = 0 -> 32'h8e4da1bc.
